// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// DmemResponderIf -- request/response bundle between the core's data-memory
// port and the memory-side responder.
//
// Signals:
//   req_valid  core -> mem   request present
//   req_ready  mem  -> core  responder can accept a request this cycle
//   req_read   core -> mem   1 = load
//   req_web    core -> mem   active-low byte write enables (bit i = lane i)
//   req_addr   core -> mem   byte address, bits [1:0] ignored
//   req_wdata  core -> mem   lane-aligned store data
//   resp_valid mem  -> core  response available
//   resp_ready core -> mem   core consumes the response
//   resp_rdata mem  -> core  raw load word, 0 for stores and errors
//   resp_err   mem  -> core  request was rejected
//
// Modports: master = core side, slave = responder side.
// ---------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic [3:0]  req_web;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_read, req_web, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_read, req_web, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder -- memory-side responder for the core's data-memory port.
//
// Accepts one load/store at a time, serves it from an internal word-addressed
// SRAM after LATENCY cycles and returns exactly one response through a
// valid/ready handshake. Out-of-range addresses and load requests carrying
// write enables are answered with resp_err = 1 and never touch the array.
//
// Parameters:
//   ADDR_W   word-address width (array = 2**ADDR_W words), must be <= 29
//   LATENCY  accept-to-resp_valid distance in cycles, 1..15
//
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset (array contents are kept)
//   i_bus  slave side of dmem_responder_if (request + response channels)
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dmem_responder_if.slave        i_bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_reqReady;
    logic                r_respValid;
    logic [31:0]         r_respRdata;
    logic                r_respErr;
    logic [31:0]         r_mem [2**ADDR_W];

    logic [ADDR_W-1:0]   w_idx;
    logic                w_outOfRange;
    logic                w_conflict;
    logic                w_err;
    logic                w_accept;
    logic                w_write;
    logic                w_unusedAddrLsbs;

    // Decode of the presented request. Everything here feeds only registers,
    // so there is no combinational path from the request to the response.
    assign w_idx            = i_bus.req_addr[ADDR_W+1:2];
    assign w_outOfRange     = |i_bus.req_addr[31:ADDR_W+2];
    assign w_conflict       = i_bus.req_read && (i_bus.req_web != 4'hf);
    assign w_err            = w_outOfRange || w_conflict;
    assign w_accept         = i_bus.req_valid && r_reqReady;
    assign w_write          = rst_n && w_accept && !i_bus.req_read && !w_err;
    assign w_unusedAddrLsbs = ^i_bus.req_addr[1:0];

    assign i_bus.req_ready  = r_reqReady;
    assign i_bus.resp_valid = r_respValid;
    assign i_bus.resp_rdata = r_respRdata;
    assign i_bus.resp_err   = r_respErr;

    // Array write port. Kept out of the reset block so the contents survive
    // reset; the write is still suppressed in a reset cycle so that reset
    // always wins over a request presented at the same edge.
    always_ff @(posedge clk) begin
        if (w_write) begin
            for (int i = 0; i < 4; i++) begin
                if (!i_bus.req_web[i]) begin
                    r_mem[w_idx][8*i +: 8] <= i_bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request/response FSM. The load word is captured at the accept edge and
    // simply held until the handshake, so the wait phase only has to count.
    // The counter is loaded with LATENCY-1 and the move to RESP happens in
    // the cycle it reads 1, which puts resp_valid exactly LATENCY cycles
    // after the accept cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_reqReady  <= 1'b1;
            r_respValid <= 1'b0;
            r_respRdata <= 32'd0;
            r_respErr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_reqReady  <= 1'b0;
                        r_respErr   <= w_err;
                        r_respRdata <= (i_bus.req_read && !w_err) ? r_mem[w_idx] : 32'd0;
                        r_cnt       <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            r_state     <= RESP;
                            r_respValid <= 1'b1;
                        end else begin
                            r_state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state     <= RESP;
                        r_respValid <= 1'b1;
                    end
                end
                RESP: begin
                    if (i_bus.resp_ready) begin
                        r_state     <= IDLE;
                        r_respValid <= 1'b0;
                        r_respRdata <= 32'd0;
                        r_respErr   <= 1'b0;
                        r_reqReady  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_reqReady  <= 1'b1;
                    r_respValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder -- directed self-checking bench for dmem_responder.
//
// Three responders are instantiated (LATENCY 2, 1 and 4). The LATENCY = 2
// instance sees every transaction; the other two only see requests while
// latMode is set, which is used to measure their accept-to-response distance.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        reqValid;
    logic        reqRead;
    logic [3:0]  reqWeb;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic        respReady;
    logic        latMode;

    int nChecks;
    int nFails;

    dmem_responder_if busL2 ();
    dmem_responder_if busL1 ();
    dmem_responder_if busL4 ();

    assign busL2.req_valid  = reqValid;
    assign busL2.req_read   = reqRead;
    assign busL2.req_web    = reqWeb;
    assign busL2.req_addr   = reqAddr;
    assign busL2.req_wdata  = reqWdata;
    assign busL2.resp_ready = respReady;

    assign busL1.req_valid  = reqValid && latMode;
    assign busL1.req_read   = reqRead;
    assign busL1.req_web    = reqWeb;
    assign busL1.req_addr   = reqAddr;
    assign busL1.req_wdata  = reqWdata;
    assign busL1.resp_ready = respReady;

    assign busL4.req_valid  = reqValid && latMode;
    assign busL4.req_read   = reqRead;
    assign busL4.req_web    = reqWeb;
    assign busL4.req_addr   = reqAddr;
    assign busL4.req_wdata  = reqWdata;
    assign busL4.resp_ready = respReady;

    dmem_responder #(.ADDR_W(14), .LATENCY(2)) dutL2 (.clk(clk), .rst_n(rst_n), .i_bus(busL2));
    dmem_responder #(.ADDR_W(14), .LATENCY(1)) dutL1 (.clk(clk), .rst_n(rst_n), .i_bus(busL1));
    dmem_responder #(.ADDR_W(14), .LATENCY(4)) dutL4 (.clk(clk), .rst_n(rst_n), .i_bus(busL4));

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle; inputs driven and outputs sampled 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one request into the LATENCY = 2 responder, wait for its response
    // and complete the handshake. Returns the measured latency, the response
    // and req_ready as seen in the cycle after acceptance.
    task automatic applyStimulus(input logic rd, input logic [3:0] web,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int lat, output logic [31:0] rdata,
                                 output logic err, output logic readyT1);
        int guard;
        guard    = 0;
        reqRead  = rd;
        reqWeb   = web;
        reqAddr  = addr;
        reqWdata = wdata;
        reqValid = 1'b1;
        while (!busL2.req_ready && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        reqValid = 1'b0;
        readyT1  = busL2.req_ready;
        lat      = 1;
        while (!busL2.resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        rdata     = busL2.resp_rdata;
        err       = busL2.resp_err;
        respReady = 1'b1;
        tick();
        respReady = 1'b0;
    endtask

    // Transaction with full result checking against hand-computed values.
    task automatic runTxn(input string tag, input logic rd, input logic [3:0] web,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] expData, input logic expErr);
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic        readyT1;
        applyStimulus(rd, web, addr, wdata, lat, rdata, err, readyT1);
        checkOutput({tag, "_rdata"}, rdata, expData);
        checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, expErr});
        checkOutput({tag, "_lat"}, lat, 32'd2);
    endtask

    // Send one request to all three responders at once and measure each
    // accept-to-resp_valid distance plus the returned data.
    task automatic latTxn(input string tag, input logic rd, input logic [3:0] web,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] expData);
        int lat1;
        int lat2;
        int lat4;
        lat1 = 0;
        lat2 = 0;
        lat4 = 0;
        latMode  = 1'b1;
        reqRead  = rd;
        reqWeb   = web;
        reqAddr  = addr;
        reqWdata = wdata;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (busL1.resp_valid && lat1 == 0) lat1 = k;
            if (busL2.resp_valid && lat2 == 0) lat2 = k;
            if (busL4.resp_valid && lat4 == 0) lat4 = k;
            if (k < 8) tick();
        end
        checkOutput({tag, "_lat1"}, lat1, 32'd1);
        checkOutput({tag, "_lat2"}, lat2, 32'd2);
        checkOutput({tag, "_lat4"}, lat4, 32'd4);
        checkOutput({tag, "_rdata1"}, busL1.resp_rdata, expData);
        checkOutput({tag, "_rdata4"}, busL4.resp_rdata, expData);
        respReady = 1'b1;
        tick();
        respReady = 1'b0;
        latMode   = 1'b0;
        checkOutput({tag, "_idle1"}, {31'd0, busL1.req_ready}, 32'd1);
        checkOutput({tag, "_idle4"}, {31'd0, busL4.req_ready}, 32'd1);
    endtask

    // Directed test sequence.
    initial begin
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic        readyT1;
        logic        stable;
        logic        sawResp;

        nChecks   = 0;
        nFails    = 0;
        rst_n     = 1'b0;
        reqValid  = 1'b0;
        reqRead   = 1'b0;
        reqWeb    = 4'hf;
        reqAddr   = 32'd0;
        reqWdata  = 32'd0;
        respReady = 1'b0;
        latMode   = 1'b0;

        tick();
        tick();
        checkOutput("rst_req_ready", {31'd0, busL2.req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'd0, busL2.resp_valid}, 32'd0);
        checkOutput("rst_resp_rdata", busL2.resp_rdata, 32'd0);
        checkOutput("rst_resp_err", {31'd0, busL2.resp_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] store / load round trip");
        applyStimulus(1'b0, 4'h0, 32'h0000_0010, 32'hDEAD_BEEF, lat, rdata, err, readyT1);
        checkOutput("sw_ready_t1", {31'd0, readyT1}, 32'd0);
        checkOutput("sw_lat", lat, 32'd2);
        checkOutput("sw_rdata", rdata, 32'd0);
        checkOutput("sw_err", {31'd0, err}, 32'd0);
        checkOutput("sw_ready_after", {31'd0, busL2.req_ready}, 32'd1);
        checkOutput("sw_valid_after", {31'd0, busL2.resp_valid}, 32'd0);
        runTxn("lw10", 1'b1, 4'hf, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);

        $display("[TB] byte and halfword lanes");
        runTxn("sw20", 1'b0, 4'h0, 32'h0000_0020, 32'h1122_3344, 32'd0, 1'b0);
        runTxn("sb20", 1'b0, 4'he, 32'h0000_0020, 32'h0000_00AA, 32'd0, 1'b0);
        runTxn("lw20_b", 1'b1, 4'hf, 32'h0000_0020, 32'd0, 32'h1122_33AA, 1'b0);
        runTxn("sh20", 1'b0, 4'hc, 32'h0000_0022, 32'h0000_BBCC, 32'd0, 1'b0);
        runTxn("lw20_h", 1'b1, 4'hf, 32'h0000_0020, 32'd0, 32'h1122_BBCC, 1'b0);
        runTxn("sb23", 1'b0, 4'h7, 32'h0000_0023, 32'h7700_0000, 32'd0, 1'b0);
        runTxn("lw20_b3", 1'b1, 4'hf, 32'h0000_0020, 32'd0, 32'h7722_BBCC, 1'b0);

        $display("[TB] error responses");
        runTxn("lw_oor", 1'b1, 4'hf, 32'h0001_0000, 32'd0, 32'd0, 1'b1);
        runTxn("sw_oor", 1'b0, 4'h0, 32'h0001_0010, 32'h0000_0000, 32'd0, 1'b1);
        runTxn("lw10_alias", 1'b1, 4'hf, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
        runTxn("ld_conflict", 1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF, 32'd0, 1'b1);
        runTxn("lw20_conf", 1'b1, 4'hf, 32'h0000_0020, 32'd0, 32'h7722_BBCC, 1'b0);
        runTxn("noop", 1'b0, 4'hf, 32'h0000_0020, 32'hFFFF_FFFF, 32'd0, 1'b0);
        runTxn("lw20_noop", 1'b1, 4'hf, 32'h0000_0020, 32'd0, 32'h7722_BBCC, 1'b0);

        $display("[TB] stray resp_ready while idle");
        respReady = 1'b1;
        tick();
        respReady = 1'b0;
        checkOutput("stray_valid", {31'd0, busL2.resp_valid}, 32'd0);
        checkOutput("stray_ready", {31'd0, busL2.req_ready}, 32'd1);

        $display("[TB] response backpressure");
        reqRead  = 1'b1;
        reqWeb   = 4'hf;
        reqAddr  = 32'h0000_0010;
        reqWdata = 32'd0;
        reqValid = 1'b1;
        tick();
        tick();
        reqValid = 1'b0;
        checkOutput("bp_valid_rise", {31'd0, busL2.resp_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("bp_hold_valid", {31'd0, busL2.resp_valid}, 32'd1);
            checkOutput("bp_hold_rdata", busL2.resp_rdata, 32'hDEAD_BEEF);
            checkOutput("bp_hold_ready", {31'd0, busL2.req_ready}, 32'd0);
        end
        respReady = 1'b1;
        tick();
        respReady = 1'b0;
        checkOutput("bp_release_ready", {31'd0, busL2.req_ready}, 32'd1);
        checkOutput("bp_release_valid", {31'd0, busL2.resp_valid}, 32'd0);
        runTxn("b2b_lw20", 1'b1, 4'hf, 32'h0000_0020, 32'd0, 32'h7722_BBCC, 1'b0);

        $display("[TB] latency 1 / 2 / 4 builds");
        latTxn("latsw", 1'b0, 4'h0, 32'h0000_0030, 32'h0BAD_F00D, 32'd0);
        latTxn("latlw", 1'b1, 4'hf, 32'h0000_0030, 32'd0, 32'h0BAD_F00D);

        $display("[TB] reset in the middle of a store");
        reqRead  = 1'b0;
        reqWeb   = 4'h0;
        reqAddr  = 32'h0000_0040;
        reqWdata = 32'h5555_5555;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
        checkOutput("mrst_ready", {31'd0, busL2.req_ready}, 32'd1);
        checkOutput("mrst_valid", {31'd0, busL2.resp_valid}, 32'd0);
        sawResp = 1'b0;
        stable  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (busL2.resp_valid) sawResp = 1'b1;
            if (!busL2.req_ready) stable = 1'b0;
        end
        checkOutput("mrst_no_resp", {31'd0, sawResp}, 32'd0);
        checkOutput("mrst_stay_ready", {31'd0, stable}, 32'd1);
        runTxn("lw40", 1'b1, 4'hf, 32'h0000_0040, 32'd0, 32'h5555_5555, 1'b0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
